// File: rtl/keypad_pkg.sv
// Shared types and helpers for the microwave keypad entry controller.
// Holds the FSM state enum, BCD digit type and key decode functions.
package keypad_pkg;
    localparam int NUM_KEYS = 10;

    typedef enum logic [1:0] {IDLE, QUALIFY, ACCEPT, RELEASE} kp_state_e;
    typedef logic [3:0] bcd_t;

    function automatic bcd_t onehot_to_code(input logic [NUM_KEYS-1:0] k);
        bcd_t code;
        code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) code = bcd_t'(i);
        end
        return code;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [NUM_KEYS-1:0] k);
        return (k & (k - NUM_KEYS'(1))) != '0;
    endfunction
endpackage

// File: rtl/keypad_hold_counter.sv
// Saturating hold counter shared by the qualify and release phases.
// clr_i with en_i loads 1, so a freshly latched key counts as its first sample.
module keypad_hold_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = en_i ? CNT_W'(1) : '0;
        end else if (en_i && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == term_i);
endmodule

// File: rtl/keypad_entry_ctrl.sv
// Microwave keypad sequencer: qualifies single key presses, rejects glitches and
// multi-key presses, and shifts accepted digits into a 4-digit MM:SS BCD register.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int QUAL_CYCLES    = 3,
    parameter int RELEASE_CYCLES = 7,
    parameter int CNT_W          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                key_clear,
    input  logic                lock,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic [3:0]          min_tens,
    output logic [3:0]          min_units,
    output logic [3:0]          sec_tens,
    output logic [3:0]          sec_units,
    output logic                entry_busy,
    output logic                multi_key_err
);
    kp_state_e           state_q;
    logic [NUM_KEYS-1:0] latched_q;
    bcd_t                key_code_q, min_tens_q, min_units_q, sec_tens_q, sec_units_q;
    logic                key_valid_q, entry_busy_q, multi_key_err_q;

    logic             any_key, multi, same, clear_go;
    logic             cnt_clr, cnt_en, cnt_done;
    logic [CNT_W-1:0] cnt_term;

    assign any_key  = |keys;
    assign multi    = popcount_gt1(keys);
    assign same     = (keys == latched_q);
    assign clear_go = key_clear & ~lock;

    // The terminal value is one less than the cycle count because the compare
    // happens on the edge that supplies the final sample.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_term = (state_q == QUALIFY) ? CNT_W'(QUAL_CYCLES - 1) : CNT_W'(RELEASE_CYCLES - 1);
        if (clear_go) begin
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!lock && any_key) begin
                        cnt_clr = 1'b1;
                        cnt_en  = ~multi;
                    end
                end
                QUALIFY: begin
                    if (lock || !any_key || multi) cnt_clr = 1'b1;
                    else if (same)                 cnt_en  = 1'b1;
                    else begin
                        cnt_clr = 1'b1;
                        cnt_en  = 1'b1;
                    end
                end
                RELEASE: begin
                    if (any_key || cnt_done) cnt_clr = 1'b1;
                    else                     cnt_en  = 1'b1;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    keypad_hold_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .done_o (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            latched_q       <= '0;
            key_valid_q     <= 1'b0;
            key_code_q      <= '0;
            min_tens_q      <= '0;
            min_units_q     <= '0;
            sec_tens_q      <= '0;
            sec_units_q     <= '0;
            entry_busy_q    <= 1'b0;
            multi_key_err_q <= 1'b0;
        end else begin
            key_valid_q     <= 1'b0;
            multi_key_err_q <= 1'b0;
            if (clear_go) begin
                key_code_q   <= '0;
                min_tens_q   <= '0;
                min_units_q  <= '0;
                sec_tens_q   <= '0;
                sec_units_q  <= '0;
                state_q      <= RELEASE;
                entry_busy_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!lock && multi) begin
                            multi_key_err_q <= 1'b1;
                            state_q         <= RELEASE;
                            entry_busy_q    <= 1'b1;
                        end else if (!lock && any_key) begin
                            latched_q    <= keys;
                            state_q      <= QUALIFY;
                            entry_busy_q <= 1'b1;
                        end
                    end
                    QUALIFY: begin
                        if (lock || !any_key) begin
                            state_q      <= IDLE;
                            entry_busy_q <= 1'b0;
                        end else if (multi) begin
                            multi_key_err_q <= 1'b1;
                            state_q         <= RELEASE;
                        end else if (!same) begin
                            latched_q <= keys;
                        end else if (cnt_done) begin
                            state_q     <= ACCEPT;
                            key_valid_q <= 1'b1;
                            key_code_q  <= onehot_to_code(latched_q);
                            min_tens_q  <= min_units_q;
                            min_units_q <= sec_tens_q;
                            sec_tens_q  <= sec_units_q;
                            sec_units_q <= onehot_to_code(latched_q);
                        end
                    end
                    ACCEPT: state_q <= RELEASE;
                    RELEASE: begin
                        if (!any_key && cnt_done) begin
                            state_q      <= IDLE;
                            entry_busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        entry_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign min_tens      = min_tens_q;
    assign min_units     = min_units_q;
    assign sec_tens      = sec_tens_q;
    assign sec_units     = sec_units_q;
    assign entry_busy    = entry_busy_q;
    assign multi_key_err = multi_key_err_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: a table-driven press, directed corner sequences and
// a randomized run, all compared against a run-length based behavioural model.
module tb_keypad_entry_ctrl;
    localparam int QUAL_CYCLES    = 3;
    localparam int RELEASE_CYCLES = 7;

    logic       clk, rst;
    logic [9:0] keys_r;
    logic       clear_r, lock_r;
    logic       key_valid, entry_busy, multi_key_err;
    logic [3:0] key_code, min_tens, min_units, sec_tens, sec_units;

    int checks = 0;
    int errors = 0;
    int n_valid, n_err;

    keypad_entry_ctrl #(.QUAL_CYCLES(QUAL_CYCLES), .RELEASE_CYCLES(RELEASE_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .keys(keys_r), .key_clear(clear_r), .lock(lock_r),
        .key_valid(key_valid), .key_code(key_code), .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units), .entry_busy(entry_busy),
        .multi_key_err(multi_key_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: "armed" means ready for a press, run is the length of the
    // current stable single-key run, rel the length of the current all-released run.
    bit         m_armed, m_acc, m_valid, m_err, m_busy;
    int         m_run, m_rel;
    logic [9:0] m_cand;
    logic [3:0] m_dig[4];
    logic [3:0] m_code;

    function automatic void model_reset();
        m_armed = 1; m_acc = 0; m_run = 0; m_rel = 0; m_cand = '0;
        for (int i = 0; i < 4; i++) m_dig[i] = '0;
        m_code = '0; m_valid = 0; m_err = 0; m_busy = 0;
    endfunction

    function automatic void model_step(input logic [9:0] k, input bit c, input bit l);
        m_valid = 0;
        m_err   = 0;
        if (c && !l) begin
            for (int i = 0; i < 4; i++) m_dig[i] = '0;
            m_code = '0; m_armed = 0; m_rel = 0; m_run = 0; m_acc = 0;
        end else if (m_acc) begin
            m_acc = 0; m_armed = 0; m_rel = 0;
        end else if (!m_armed) begin
            if (k == '0) m_rel++;
            else         m_rel = 0;
            if (m_rel >= RELEASE_CYCLES) m_armed = 1;
            m_run = 0;
        end else if (l) begin
            m_run = 0;
        end else if ($countones(k) > 1) begin
            m_err = 1; m_armed = 0; m_rel = 0; m_run = 0;
        end else if (k == '0) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && k == m_cand) m_run++;
            else begin
                m_cand = k;
                m_run  = 1;
            end
            if (m_run >= QUAL_CYCLES) begin
                for (int i = 0; i < 10; i++) if (k[i]) m_code = 4'(i);
                m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = m_code;
                m_valid = 1; m_acc = 1; m_run = 0;
            end
        end
        m_busy = m_acc || !m_armed || (m_run > 0);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("key_valid", 16'(key_valid), 16'(m_valid));
        chk("multi_key_err", 16'(multi_key_err), 16'(m_err));
        chk("entry_busy", 16'(entry_busy), 16'(m_busy));
        chk("key_code", 16'(key_code), 16'(m_code));
        chk("digits", {min_tens, min_units, sec_tens, sec_units}, {m_dig[0], m_dig[1], m_dig[2], m_dig[3]});
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, 16'(key_valid), 16'h0);
        chk({name, "_err"}, 16'(multi_key_err), 16'h0);
        chk({name, "_busy"}, 16'(entry_busy), 16'h0);
        chk({name, "_code"}, 16'(key_code), 16'h0);
        chk({name, "_digits"}, {min_tens, min_units, sec_tens, sec_units}, 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(keys_r, clear_r, lock_r);
        #1;
        if (key_valid) n_valid++;
        if (multi_key_err) n_err++;
        compare_model();
    endtask

    task automatic press(input int d, input int hold);
        keys_r = 10'(1) << d;
        repeat (hold) tick();
        keys_r = '0;
        repeat (RELEASE_CYCLES + 1) tick();
    endtask

    task automatic async_reset(input string name);
        #2 rst = 1'b1;
        keys_r = '0; clear_r = 1'b0; lock_r = 1'b0;
        #1 check_zero(name);
        #1 rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [9:0]  keys;
        logic        clr;
        logic        lk;
        logic        exp_valid;
        logic        exp_busy;
        logic [3:0]  exp_code;
        logic [15:0] exp_dig;
    } vec_t;
    vec_t tbl[17];

    initial begin
        rst = 1'b1; keys_r = '0; clear_r = 1'b0; lock_r = 1'b0;
        n_valid = 0; n_err = 0;
        model_reset();
        for (int i = 0; i < 17; i++) begin
            tbl[i].keys      = (i < 10) ? 10'b00_0010_0000 : 10'b0;
            tbl[i].clr       = 1'b0;
            tbl[i].lk        = 1'b0;
            tbl[i].exp_valid = (i == QUAL_CYCLES - 1);
            tbl[i].exp_busy  = (i < 10 + RELEASE_CYCLES - 1);
            tbl[i].exp_code  = (i >= QUAL_CYCLES - 1) ? 4'd5 : 4'd0;
            tbl[i].exp_dig   = (i >= QUAL_CYCLES - 1) ? 16'h0005 : 16'h0000;
        end
        #12 check_zero("reset");
        rst = 1'b0;

        // keys[5] held for 10 cycles, then released
        for (int i = 0; i < 17; i++) begin
            keys_r = tbl[i].keys; clear_r = tbl[i].clr; lock_r = tbl[i].lk;
            tick();
            chk($sformatf("tbl%0d_valid", i), 16'(key_valid), 16'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_busy", i), 16'(entry_busy), 16'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_code", i), 16'(key_code), 16'(tbl[i].exp_code));
            chk($sformatf("tbl%0d_digits", i), {min_tens, min_units, sec_tens, sec_units}, tbl[i].exp_dig);
        end
        keys_r = '0;
        tick();

        // five digits in sequence
        n_valid = 0;
        for (int d = 1; d <= 5; d++) press(d, 4);
        chk("seq_pulses", 16'(n_valid), 16'd5);
        chk("seq_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h2345);

        // two-cycle glitch on key 7
        n_valid = 0;
        press(7, 2);
        chk("glitch_pulses", 16'(n_valid), 16'd0);
        chk("glitch_busy", 16'(entry_busy), 16'd0);
        chk("glitch_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h2345);

        // keys 2 and 8 together, then a clean press of 4
        n_valid = 0; n_err = 0;
        keys_r = 10'b01_0000_0100;
        tick();
        keys_r = '0;
        repeat (RELEASE_CYCLES + 1) tick();
        chk("multi_err_pulses", 16'(n_err), 16'd1);
        chk("multi_no_valid", 16'(n_valid), 16'd0);
        press(4, 4);
        chk("multi_after_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h3454);

        // clear on the accept edge, then lock with key 9 held
        async_reset("rst_pre_clear");
        press(1, 4); press(3, 4); press(0, 4);
        chk("pre_clear_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h0130);
        n_valid = 0;
        keys_r = 10'(1) << 7;
        tick(); tick();
        clear_r = 1'b1;
        tick();
        clear_r = 1'b0;
        chk("clear_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h0000);
        chk("clear_code", 16'(key_code), 16'h0);
        chk("clear_valid", 16'(key_valid), 16'h0);
        keys_r = '0;
        repeat (RELEASE_CYCLES + 1) tick();
        lock_r = 1'b1;
        keys_r = 10'(1) << 9;
        repeat (20) tick();
        chk("lock_pulses", 16'(n_valid), 16'd0);
        chk("lock_busy", 16'(entry_busy), 16'd0);
        lock_r = 1'b0; keys_r = '0;
        tick();

        // asynchronous reset in QUALIFY and in RELEASE
        press(9, 4);
        keys_r = 10'(1) << 3;
        tick(); tick();
        chk("pre_rst_busy", 16'(entry_busy), 16'd1);
        async_reset("rst_qualify");
        press(8, 1);
        keys_r = 10'(1) << 8;
        repeat (QUAL_CYCLES + 2) tick();
        chk("pre_rst2_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h0008);
        async_reset("rst_release");
        n_valid = 0;
        press(6, 4);
        chk("post_rst_pulses", 16'(n_valid), 16'd1);
        chk("post_rst_code", 16'(key_code), 16'd6);
        chk("post_rst_digits", {min_tens, min_units, sec_tens, sec_units}, 16'h0006);

        // randomized stimulus against the model
        for (int n = 0; n < 400; n++) begin
            int r, hold, a, b;
            r    = $urandom_range(0, 99);
            hold = $urandom_range(1, 9);
            a    = $urandom_range(0, 9);
            b    = (a + 1 + $urandom_range(0, 8)) % 10;
            if (r < 40)      keys_r = '0;
            else if (r < 88) keys_r = 10'(1) << a;
            else             keys_r = (10'(1) << a) | (10'(1) << b);
            lock_r  = ($urandom_range(0, 99) < 8);
            clear_r = ($urandom_range(0, 99) < 4);
            for (int h = 0; h < hold; h++) begin
                tick();
                clear_r = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences the microwave numeric keypad. It qualifies key presses with a hold counter and rejects glitches and multi-key presses. Each accepted digit shifts into a 4-digit BCD cook-time register (MM:SS) that feeds the countdown datapath. It also handles CLEAR and a LOCK input, which is held high while the oven runs.

Parameters:
QUAL_CYCLES, 3, consecutive clk cycles a single key must stay stable before it is accepted (legal range 2..15)
RELEASE_CYCLES, 7, consecutive all-released cycles required before the next press is accepted (legal range 1..15)
CNT_W, 4, width of the internal qualify/release counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
keys  input  10  key lines 0..9, active-high, already synchronous to clk
key_clear  input  1  CLEAR key, level, active-high
lock  input  1  high = oven running; digit entry and clear are ignored
key_valid  output  1  one-cycle pulse when a digit is accepted
key_code  output  4  binary code of the last accepted digit (0..9)
min_tens  output  4  BCD cook-time digit
min_units  output  4  BCD cook-time digit
sec_tens  output  4  BCD cook-time digit
sec_units  output  4  BCD cook-time digit
entry_busy  output  1  high whenever the FSM is not IDLE
multi_key_err  output  1  one-cycle pulse when more than one key is seen

Behaviour:
- Reset (asynchronous, active-high):
  - all outputs go to 0 and the FSM goes to IDLE;
  - the counter and the latched key are cleared;
  - reset asserted mid-operation aborts the operation without emitting a key_valid pulse.
- All outputs are registered. Every value change occurs on a clk rising edge.
- FSM states: IDLE, QUALIFY, ACCEPT, RELEASE.
- IDLE:
  - lock=1: stay in IDLE.
  - keys has exactly one bit set: latch that one-hot value, cnt<=1, go to QUALIFY.
  - keys has two or more bits set: pulse multi_key_err, cnt<=0, go to RELEASE.
  - keys==0: stay in IDLE.
- QUALIFY:
  - keys equals the latched value and cnt==QUAL_CYCLES: go to ACCEPT; on the same edge, shift the digits and set key_code, with key_valid high for the following cycle.
  - keys equals the latched value and cnt<QUAL_CYCLES: cnt++.
  - keys==0: return to IDLE with no accept (glitch rejected).
  - a different single key: re-latch the new key, cnt<=1, stay in QUALIFY.
  - two or more keys: pulse multi_key_err, cnt<=0, go to RELEASE.
- Latency: key first sampled at edge T gives key_valid high in the cycle after edge T+QUAL_CYCLES-1. With the default QUAL_CYCLES=3, key_valid is high between edges T+2 and T+3.
- ACCEPT: lasts exactly one cycle, then cnt<=0 and go to RELEASE. key_valid deasserts on exit.
- RELEASE:
  - keys==0: cnt++; when cnt reaches RELEASE_CYCLES, go to IDLE.
  - any key asserted: cnt<=0 (a held key never repeats).
- Digit shift on accept:
  - min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key_code.
  - The old min_tens is discarded (no overflow flag).
  - No range check on the MM:SS value; the downstream timer normalises.
- key_code holds the last accepted digit until the next accept, clear or reset.
- Clear (key_clear=1 and lock=0):
  - at the next edge, all four digits and key_code go to 0 and the FSM goes to RELEASE with cnt<=0;
  - clear has priority over a simultaneous accept (no key_valid pulse that cycle).
- lock rising while in QUALIFY: abort to IDLE, no accept.
- lock while in RELEASE or ACCEPT: the sequence completes normally. An ACCEPT already entered still shifts.
- keys one-hot to code: index of the set bit (bit 0 -> 0 ... bit 9 -> 9).

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state enum (IDLE, QUALIFY, ACCEPT, RELEASE);
  - BCD digit type (4 bits);
  - NUM_KEYS=10;
  - a function onehot_to_code and a function popcount_gt1.
- One sub-module, keypad_hold_counter: a saturating CNT_W counter with clear, enable and terminal-compare, instantiated once and shared by QUALIFY and RELEASE.

Test Plan:
- Reset, then keys[5] held for 10 cycles -> exactly one key_valid pulse in the cycle after edge T+2; key_code=5; digits 0,0,0,5; entry_busy=1 until 7 released cycles, then 0.
- Accept 1, 2, 3, 4, 5 in sequence, each press separated by at least 7 released cycles -> digits min_tens..sec_units = 2,3,4,5; five key_valid pulses total.
- keys[7] asserted for 2 cycles then released -> no key_valid; FSM back in IDLE; digits unchanged.
- keys[2] and keys[8] asserted on the same edge -> one multi_key_err pulse, no key_valid; a subsequent clean press of 4 (after 7 released cycles) is accepted.
- Digits 0,1,3,0, then key_clear=1 on the same edge the FSM would enter ACCEPT -> all digits 0, key_code=0, no key_valid; lock=1 with keys[9] held for 20 cycles -> no response.
- Assert rst while in QUALIFY and again mid-RELEASE -> all outputs 0 immediately (without waiting for clk); after rst falls, a clean press of 6 is accepted normally.
